datamem_lsu: RTL and testbench

- Load/store initiator that drives the single-port data memory from a SIMD core.
- Accepts one vector load or store request covering N_LANES lanes plus an active-lane mask.
- Serialises the request into one memory access per cycle, in ascending lane order, skipping inactive lanes.
- Gathers load results into a per-lane result bus and pulses Done when the whole vector has completed.
- Sits between the core's execute stage and the data memory; its Mem* ports connect one-to-one to the memory's clk/MemWrite/Address/WriteData/ReadData.

---
 rtl/datamem_lsu_if.sv | 30 +++
 rtl/datamem_lsu.sv | 96 +++++++++
 tb/tb_datamem_lsu.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/datamem_lsu_if.sv
// Core-side request bus and memory-side access bus of the SIMD load/store unit.
// The core/memory environment takes master; the LSU takes slave.
interface datamem_lsu_if #(
    parameter int N_LANES = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic                      Start;
    logic                      IsStore;
    logic [N_LANES-1:0]        LaneMask;
    logic [N_LANES*ADDR_W-1:0] LaneAddr;
    logic [N_LANES*DATA_W-1:0] LaneWData;
    logic                      Ready;
    logic                      Done;
    logic [N_LANES*DATA_W-1:0] LaneRData;
    logic                      MemWrite;
    logic [ADDR_W-1:0]         Address;
    logic [DATA_W-1:0]         WriteData;
    logic [DATA_W-1:0]         ReadData;

    modport master (
        output Start, IsStore, LaneMask, LaneAddr, LaneWData, ReadData,
        input  Ready, Done, LaneRData, MemWrite, Address, WriteData
    );

    modport slave (
        input  Start, IsStore, LaneMask, LaneAddr, LaneWData, ReadData,
        output Ready, Done, LaneRData, MemWrite, Address, WriteData
    );
endinterface

// File: rtl/datamem_lsu.sv
// Vector load/store initiator: serialises active lanes into one
// single-port memory access per cycle, lowest lane first.
module datamem_lsu #(
    parameter int N_LANES = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    datamem_lsu_if.slave bus
);
    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

    state_e               state_q;
    logic                 store_q;
    logic [N_LANES-1:0]   mask_q;
    logic [N_LANES-1:0]   mask_d;
    logic [ADDR_W-1:0]    addr_q  [N_LANES];
    logic [DATA_W-1:0]    wdata_q [N_LANES];
    logic [DATA_W-1:0]    rdata_q [N_LANES];
    logic [LW-1:0]        lane;
    logic                 found;
    logic                 issue;

    // Lowest pending lane is the one served this cycle.
    always_comb begin
        lane  = '0;
        found = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            if (!found && mask_q[i]) begin
                lane  = LW'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        mask_d       = mask_q;
        mask_d[lane] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            mask_q  <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        store_q <= bus.IsStore;
                        mask_q  <= bus.LaneMask;
                        for (int i = 0; i < N_LANES; i++) begin
                            addr_q[i]  <= bus.LaneAddr[i*ADDR_W +: ADDR_W];
                            wdata_q[i] <= bus.LaneWData[i*DATA_W +: DATA_W];
                        end
                        state_q <= (|bus.LaneMask) ? ISSUE : DONE;
                    end
                end
                ISSUE: begin
                    if (!store_q) begin
                        rdata_q[lane] <= bus.ReadData;
                    end
                    mask_q <= mask_d;
                    if (mask_d == '0) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory strobes are decoded from state so reset kills them at once.
    assign issue         = (state_q == ISSUE);
    assign bus.Ready     = (state_q == IDLE);
    assign bus.Done      = (state_q == DONE);
    assign bus.MemWrite  = issue & store_q;
    assign bus.Address   = issue ? addr_q[lane] : '0;
    assign bus.WriteData = (issue && store_q) ? wdata_q[lane] : '0;

    always_comb begin
        bus.LaneRData = '0;
        for (int i = 0; i < N_LANES; i++) begin
            bus.LaneRData[i*DATA_W +: DATA_W] = rdata_q[i];
        end
    end
endmodule

// File: tb/tb_datamem_lsu.sv
// Randomised bench for datamem_lsu with a per-cycle expectation queue
// and a reference memory image.
module tb_datamem_lsu;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datamem_lsu_if #(.N_LANES(4), .ADDR_W(8), .DATA_W(8)) bus ();

    datamem_lsu #(.N_LANES(4), .ADDR_W(8), .DATA_W(8)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    logic [7:0] mem [256];

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end

    assign bus.ReadData = mem[bus.Address];

    always @(posedge clk) begin
        if (bus.MemWrite) mem[bus.Address] <= bus.WriteData;
    end

    typedef struct {
        bit         done;
        bit         we;
        int         lane;
        logic [7:0] addr;
        logic [7:0] wdata;
    } rec_t;

    rec_t       q [$];
    logic [7:0] ref_mem [256];
    logic [7:0] rd_model [4];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_rd();
        return {rd_model[3], rd_model[2], rd_model[1], rd_model[0]};
    endfunction

    // Per-cycle compare against the expected access sequence.
    initial begin
        rec_t r;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < 4; i++) rd_model[i] = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                q.delete();
                for (int i = 0; i < 4; i++) rd_model[i] = '0;
                chk("reset_out",
                    {bus.Ready, bus.Done, bus.MemWrite, bus.Address,
                     bus.WriteData, bus.LaneRData},
                    {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0});
            end else if (q.size() == 0) begin
                chk("idle_out",
                    {bus.Ready, bus.Done, bus.MemWrite, bus.Address,
                     bus.WriteData, bus.LaneRData},
                    {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, pack_rd()});
            end else begin
                r = q.pop_front();
                if (r.done) begin
                    chk("done_out",
                        {bus.Ready, bus.Done, bus.MemWrite, bus.Address,
                         bus.WriteData, bus.LaneRData},
                        {1'b0, 1'b1, 1'b0, 8'd0, 8'd0, pack_rd()});
                end else begin
                    chk("access_out",
                        {bus.Ready, bus.Done, bus.MemWrite, bus.Address,
                         bus.WriteData},
                        {1'b0, 1'b0, r.we, r.addr, r.wdata});
                    if (r.we) ref_mem[r.addr] = r.wdata;
                    else rd_model[r.lane] = ref_mem[r.addr];
                end
            end
        end
    end

    task automatic push_req(input bit st, input logic [3:0] m,
                            input logic [31:0] a, input logic [31:0] d);
        rec_t r;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                r.done  = 1'b0;
                r.we    = st;
                r.lane  = i;
                r.addr  = a[i*8 +: 8];
                r.wdata = st ? d[i*8 +: 8] : 8'd0;
                q.push_back(r);
            end
        end
        r.done  = 1'b1;
        r.we    = 1'b0;
        r.lane  = 0;
        r.addr  = '0;
        r.wdata = '0;
        q.push_back(r);
    endtask

    task automatic start_req(input bit st, input logic [3:0] m,
                             input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.Start     = 1'b1;
        bus.IsStore   = st;
        bus.LaneMask  = m;
        bus.LaneAddr  = a;
        bus.LaneWData = d;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        push_req(st, m, a, d);
    endtask

    task automatic run_req(input bit st, input logic [3:0] m,
                           input logic [31:0] a, input logic [31:0] d,
                           input bit noisy, output int lat);
        start_req(st, m, a, d);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (bus.Done) break;
            if (lat > 20) begin
                checks++;
                errors++;
                $display("FAIL done_timeout act=none exp=done_within_20");
                break;
            end
            if (noisy) begin
                bus.Start     = 1'($urandom);
                bus.IsStore   = 1'($urandom);
                bus.LaneMask  = 4'($urandom);
                bus.LaneAddr  = $urandom;
                bus.LaneWData = $urandom;
            end
        end
        bus.Start = 1'b0;
    endtask

    initial begin
        int lat;
        logic [31:0] a;
        logic [3:0]  m;
        bit          st;
        bus.Start     = 1'b0;
        bus.IsStore   = 1'b0;
        bus.LaneMask  = '0;
        bus.LaneAddr  = '0;
        bus.LaneWData = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("t1_in_reset",
            {bus.Ready, bus.Done, bus.MemWrite, bus.Address, bus.LaneRData},
            {1'b1, 1'b0, 1'b0, 8'd0, 32'd0});
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("t1_released",
            {bus.Ready, bus.Done, bus.MemWrite, bus.Address, bus.LaneRData},
            {1'b1, 1'b0, 1'b0, 8'd0, 32'd0});

        run_req(1'b1, 4'hf, {8'd13, 8'd12, 8'd11, 8'd10},
                32'hA3A2A1A0, 1'b0, lat);
        chk("t2_latency", lat, 5);
        @(negedge clk);
        chk("t2_mem", {mem[13], mem[12], mem[11], mem[10]}, 32'hA3A2A1A0);

        run_req(1'b0, 4'hf, {8'd13, 8'd12, 8'd11, 8'd10}, 32'h0, 1'b0, lat);
        chk("t3_latency", lat, 5);
        chk("t3_rdata", bus.LaneRData, 32'hA3A2A1A0);
        @(negedge clk);
        chk("t3_ready_after", bus.Ready, 1'b1);

        run_req(1'b0, 4'h5, {8'd13, 8'd10, 8'd11, 8'd12}, 32'h0, 1'b1, lat);
        chk("t4_latency", lat, 3);
        chk("t4_rdata", bus.LaneRData, 32'hA3A0A1A2);

        run_req(1'b0, 4'h0, 32'h01020304, 32'h0, 1'b1, lat);
        chk("t5_load_latency", lat, 1);
        run_req(1'b1, 4'h0, {8'd10, 8'd10, 8'd10, 8'd10},
                32'h55555555, 1'b1, lat);
        chk("t5_store_latency", lat, 1);
        chk("t5_rdata_kept", bus.LaneRData, 32'hA3A0A1A2);
        chk("t5_mem_kept", mem[10], 8'hA0);

        run_req(1'b1, 4'hf, {4{8'd20}}, 32'h04030201, 1'b1, lat);
        chk("t6_latency", lat, 5);
        @(negedge clk);
        chk("t6_mem20", mem[20], 8'd4);

        start_req(1'b1, 4'hf, {4{8'd20}}, 32'h08070605);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("t6_abort_out", {bus.Ready, bus.Done, bus.MemWrite},
            {1'b1, 1'b0, 1'b0});
        chk("t6_abort_mem20", mem[20], 8'd6);
        @(posedge clk); #1 reset_n = 1'b1;

        for (int n = 0; n < 80; n++) begin
            st = 1'($urandom);
            m  = 4'($urandom);
            for (int i = 0; i < 4; i++) a[i*8 +: 8] = 8'($urandom_range(0, 15));
            run_req(st, m, a, $urandom, 1'($urandom), lat);
            chk("rand_latency", lat, 1 + $countones(m));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (2) @(negedge clk);
        begin
            int bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
            chk("final_mem_image", bad, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
